// File: rtl/gc_refresh_scheduler.sv
// Refresh sequencer: a retention timer triggers a sweep that copies every row of the
// source bank into the spare bank, then rotates the source into the spare role.
module gc_refresh_scheduler #(
    parameter int unsigned NUM_BANKS  = 4,
    parameter int unsigned BANK_W     = 2,
    parameter int unsigned ROWS       = 128,
    parameter int unsigned ADDR_W     = 7,
    parameter int unsigned RET_CYCLES = 4096
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic                 u_re,
    input  logic [BANK_W-1:0]    u_re_bank,
    input  logic                 sr_ind_src,
    output logic [NUM_BANKS-1:0] ref_en_current,
    output logic [NUM_BANKS-1:0] ref_en_old,
    output logic [ADDR_W-1:0]    ref_row,
    output logic [BANK_W-1:0]    src_bank,
    output logic [BANK_W-1:0]    spare_bank,
    output logic                 ref_busy,
    output logic                 sweep_done,
    output logic                 ref_overdue
);

    localparam int unsigned TIMER_W = $clog2(RET_CYCLES);
    localparam logic [TIMER_W-1:0] TimerLast = TIMER_W'(RET_CYCLES - 1);
    localparam logic [ADDR_W-1:0]  RowLast   = ADDR_W'(ROWS - 1);
    localparam logic [NUM_BANKS-1:0] OneHot0 = {{(NUM_BANKS-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {StIdle, StWait, StCopy, StRotate} state_e;

    state_e               state_q, state_d;
    logic [TIMER_W-1:0]   timer_q, timer_d;
    logic [ADDR_W-1:0]    row_q, row_d;
    logic [BANK_W-1:0]    src_q, src_d;
    logic [BANK_W-1:0]    spare_q, spare_d;
    logic                 pending_q, pending_d;
    logic                 overdue_q, overdue_d;

    logic                 timer_run;
    logic                 expire;
    logic                 stall;
    logic [BANK_W-1:0]    src_inc1, src_inc2;

    assign timer_run = en && (state_q != StIdle);
    assign expire    = timer_run && (timer_q == TimerLast);
    assign stall     = u_re && (u_re_bank == src_q);
    assign src_inc1  = BANK_W'((32'(src_q) + 32'd1) % NUM_BANKS);
    assign src_inc2  = BANK_W'((32'(src_q) + 32'd2) % NUM_BANKS);

    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        row_d     = row_q;
        src_d     = src_q;
        spare_d   = spare_q;
        pending_d = pending_q;
        overdue_d = overdue_q;

        if (timer_run) begin
            timer_d = expire ? '0 : timer_q + TIMER_W'(1);
        end

        unique case (state_q)
            StIdle: begin
                if (en) state_d = StWait;
            end
            StWait: begin
                if (expire || pending_q) begin
                    state_d   = StCopy;
                    pending_d = 1'b0;
                end
            end
            StCopy: begin
                // Expiry during a sweep is remembered so the next sweep starts right after rotation.
                if (expire) begin
                    pending_d = 1'b1;
                    overdue_d = 1'b1;
                end
                if (!stall) begin
                    if (row_q == RowLast) begin
                        row_d   = '0;
                        state_d = StRotate;
                    end else begin
                        row_d = row_q + ADDR_W'(1);
                    end
                end
            end
            StRotate: begin
                if (expire) overdue_d = 1'b1;
                spare_d = src_q;
                src_d   = (src_inc1 == src_q) ? src_inc2 : src_inc1;
                if (pending_q || expire) begin
                    state_d   = StCopy;
                    pending_d = 1'b0;
                end else begin
                    state_d = StWait;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            timer_q   <= '0;
            row_q     <= '0;
            src_q     <= '0;
            spare_q   <= BANK_W'(NUM_BANKS - 1);
            pending_q <= 1'b0;
            overdue_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            row_q     <= row_d;
            src_q     <= src_d;
            spare_q   <= spare_d;
            pending_q <= pending_d;
            overdue_q <= overdue_d;
        end
    end

    always_comb begin
        ref_en_current = '0;
        ref_en_old     = '0;
        if (state_q == StCopy && !stall) begin
            ref_en_current = OneHot0 << src_q;
            // A row already fresh in the spare is skipped without a write.
            if (!sr_ind_src) ref_en_old = OneHot0 << spare_q;
        end
    end

    assign ref_row     = row_q;
    assign src_bank    = src_q;
    assign spare_bank  = spare_q;
    assign ref_busy    = (state_q == StCopy);
    assign sweep_done  = (state_q == StRotate);
    assign ref_overdue = overdue_q;

endmodule

// File: tb/tb_gc_refresh_scheduler.sv
// Bench for gc_refresh_scheduler: directed sweeps plus random traffic, every cycle compared
// against a behavioural model of the sweep/rotation rules.
module tb_gc_refresh_scheduler;

    localparam int unsigned NB   = 4;
    localparam int unsigned BW   = 2;
    localparam int unsigned ROWS = 16;
    localparam int unsigned AW   = 4;
    localparam int unsigned RET  = 24;

    logic          clk = 1'b0;
    logic          rst_n, en, u_re, sr_ind_src;
    logic [BW-1:0] u_re_bank;
    logic [NB-1:0] ref_en_current, ref_en_old;
    logic [AW-1:0] ref_row;
    logic [BW-1:0] src_bank, spare_bank;
    logic          ref_busy, sweep_done, ref_overdue;

    gc_refresh_scheduler #(
        .NUM_BANKS(NB), .BANK_W(BW), .ROWS(ROWS), .ADDR_W(AW), .RET_CYCLES(RET)
    ) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .u_re(u_re), .u_re_bank(u_re_bank),
        .sr_ind_src(sr_ind_src), .ref_en_current(ref_en_current), .ref_en_old(ref_en_old),
        .ref_row(ref_row), .src_bank(src_bank), .spare_bank(spare_bank),
        .ref_busy(ref_busy), .sweep_done(sweep_done), .ref_overdue(ref_overdue)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Model: phase 0 idle, 1 waiting, 2 copying, 3 rotating.
    int m_phase, m_timer, m_row, m_src, m_spare;
    bit m_pend, m_over;
    bit seen_busy, seen_done;
    int stim_mode, stall_cnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_phase = 0; m_timer = 0; m_row = 0; m_src = 0; m_spare = NB - 1;
        m_pend = 0; m_over = 0;
    endtask

    task automatic model_step();
        bit fire, blocked;
        int nxt;
        if (!rst_n) begin
            model_reset();
            return;
        end
        fire    = (m_phase != 0) && en && (m_timer == RET - 1);
        blocked = u_re && (int'(u_re_bank) == m_src);
        if (m_phase != 0 && en) m_timer = fire ? 0 : m_timer + 1;
        case (m_phase)
            0: if (en) m_phase = 1;
            1: if (fire || m_pend) begin m_phase = 2; m_pend = 0; end
            2: begin
                if (fire) begin m_pend = 1; m_over = 1; end
                if (!blocked) begin
                    m_row = (m_row + 1) % ROWS;
                    if (m_row == 0) m_phase = 3;
                end
            end
            default: begin
                if (fire) m_over = 1;
                nxt = (m_src + 1) % NB;
                if (nxt == m_src) nxt = (m_src + 2) % NB;
                m_spare = m_src;
                m_src   = nxt;
                if (m_pend || fire) begin m_phase = 2; m_pend = 0; end
                else m_phase = 1;
            end
        endcase
    endtask

    // Compare at the falling edge, update the model, then release inputs 1 time unit after rise.
    task automatic run_cycle();
        bit copying, blocked;
        logic [31:0] e_cur, e_old;
        @(negedge clk);
        copying = (m_phase == 2);
        blocked = u_re && (int'(u_re_bank) == m_src);
        e_cur = (copying && !blocked) ? (32'd1 << m_src) : 32'd0;
        e_old = (copying && !blocked && !sr_ind_src) ? (32'd1 << m_spare) : 32'd0;
        chk("ref_en_current", 32'(ref_en_current), e_cur);
        chk("ref_en_old", 32'(ref_en_old), e_old);
        chk("ref_row", 32'(ref_row), m_row);
        chk("src_bank", 32'(src_bank), m_src);
        chk("spare_bank", 32'(spare_bank), m_spare);
        chk("ref_busy", 32'(ref_busy), 32'(copying));
        chk("sweep_done", 32'(sweep_done), 32'(m_phase == 3));
        chk("ref_overdue", 32'(ref_overdue), 32'(m_over));
        seen_busy = ref_busy;
        seen_done = sweep_done;
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_inputs();
        u_re = 0; u_re_bank = 0; sr_ind_src = 0;
        case (stim_mode)
            1: if (m_phase == 2 && m_row == 5 && stall_cnt < 2) begin
                u_re = 1; u_re_bank = BW'(m_src); stall_cnt++;
            end
            2: if (m_phase == 2) begin u_re = 1; u_re_bank = BW'((m_src + 1) % NB); end
            3: if (m_phase == 2 && m_row == 10) sr_ind_src = 1;
            4: if (m_phase == 2 && m_row == 3 && stall_cnt < 12) begin
                u_re = 1; u_re_bank = BW'(m_src); stall_cnt++;
            end
            default: ;
        endcase
    endtask

    task automatic wait_done(input string tag, output int copy_cycles);
        bit got;
        got = 0;
        copy_cycles = 0;
        stall_cnt = 0;
        for (int i = 0; i < 4 * RET + 4 * ROWS && !got; i++) begin
            set_inputs();
            run_cycle();
            if (seen_busy) copy_cycles++;
            if (seen_done) got = 1;
        end
        chk({tag, "_timeout"}, 32'(got), 32'd1);
    endtask

    int n, k;
    bit got_busy;

    initial begin
        rst_n = 0; en = 0; u_re = 0; u_re_bank = 0; sr_ind_src = 0; stim_mode = 0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        run_cycle();
        chk("reset_spare", 32'(spare_bank), NB - 1);

        // First sweep: IDLE->WAIT takes one cycle, then RET waiting cycles.
        rst_n = 1; en = 1;
        n = 0; got_busy = 0;
        for (int i = 0; i < RET + 10 && !got_busy; i++) begin
            run_cycle();
            n++;
            got_busy = seen_busy;
        end
        chk("busy_latency", n, RET + 2);
        wait_done("sweep1", k);
        chk("sweep1_len", k, ROWS - 1);
        chk("rot1_src", 32'(src_bank), 1);
        chk("rot1_spare", 32'(spare_bank), 0);

        stim_mode = 1;
        wait_done("stall", k);
        chk("stall_len", k, ROWS + 2);
        stim_mode = 2;
        wait_done("nonsrc", k);
        chk("nonsrc_len", k, ROWS);
        stim_mode = 3;
        wait_done("skip", k);
        chk("skip_len", k, ROWS);

        // Long stall pushes the expiry into COPY: overdue, then back-to-back sweep.
        stim_mode = 4;
        wait_done("overdue", k);
        chk("overdue_len", k, ROWS + 12);
        chk("overdue_flag", 32'(ref_overdue), 1);
        stim_mode = 0;
        run_cycle();
        chk("back_to_back", 32'(seen_busy), 1);
        wait_done("drain", k);

        // Reset in the middle of a sweep abandons it.
        got_busy = 0;
        for (int i = 0; i < 4 * RET && !got_busy; i++) begin
            run_cycle();
            got_busy = (m_phase == 2 && m_row == ROWS / 2);
        end
        chk("reach_mid", 32'(got_busy), 1);
        rst_n = 0;
        run_cycle();
        chk("mid_rst_busy", 32'(ref_busy), 0);
        chk("mid_rst_row", 32'(ref_row), 0);
        chk("mid_rst_src", 32'(src_bank), 0);
        chk("mid_rst_spare", 32'(spare_bank), NB - 1);
        chk("mid_rst_over", 32'(ref_overdue), 0);
        rst_n = 1;
        for (int s = 1; s <= 4; s++) begin
            wait_done("rot", k);
            chk("rot_src", 32'(src_bank), s % NB);
            chk("rot_spare", 32'(spare_bank), s - 1);
        end

        // Random traffic including en drops and occasional resets.
        for (int i = 0; i < 1500; i++) begin
            en         = ($urandom_range(9) != 0);
            u_re       = ($urandom_range(2) == 0);
            u_re_bank  = BW'($urandom_range(NB - 1));
            sr_ind_src = ($urandom_range(4) == 0);
            rst_n      = ($urandom_range(299) != 0);
            run_cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
